i2c_master_arbiter: RTL and testbench

- Shares one I2C master engine between NREQ independent requesters (sensor poller, config loader, debug bridge) that each issue single-byte writes to I2C slaves such as i2c_slave_controller.
- Round-robin arbitration with per-requester latched address/data.
- Launches the transaction and supervises it with a timeout.
- Returns done, nack and timeout status to the winning requester only.

---
 rtl/i2c_arb_pkg.sv | 12 +
 rtl/i2c_master_arbiter_if.sv | 28 ++
 rtl/i2c_rr_picker.sv | 29 ++
 rtl/i2c_master_arbiter.sv | 105 ++++++++++
 tb/tb_i2c_master_arbiter.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/i2c_arb_pkg.sv
// Shared encodings and field widths for the I2C master arbiter.
package i2c_arb_pkg;
  localparam int I2C_ADDR_W = 7;
  localparam int I2C_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } arb_state_e;
endpackage

// File: rtl/i2c_master_arbiter_if.sv
// Requester and master-engine signals of the arbiter; master = arbiter side, slave = environment side.
interface i2c_master_arbiter_if import i2c_arb_pkg::*; #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]            req;
  logic [I2C_ADDR_W*NREQ-1:0] req_addr;
  logic [I2C_DATA_W*NREQ-1:0] req_data;
  logic [NREQ-1:0]            grant;
  logic [NREQ-1:0]            done;
  logic [NREQ-1:0]            nack;
  logic [NREQ-1:0]            timeout;
  logic                       m_start;
  logic [I2C_ADDR_W-1:0]      m_addr;
  logic [I2C_DATA_W-1:0]      m_data;
  logic                       m_busy;
  logic                       m_done;
  logic                       m_ack;

  modport master (
    input  req, req_addr, req_data, m_busy, m_done, m_ack,
    output grant, done, nack, timeout, m_start, m_addr, m_data
  );

  modport slave (
    output req, req_addr, req_data, m_busy, m_done, m_ack,
    input  grant, done, nack, timeout, m_start, m_addr, m_data
  );
endinterface

// File: rtl/i2c_rr_picker.sv
// Combinational circular priority picker: first set req bit searching from ptr+1.
module i2c_rr_picker #(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic            valid,
  output logic [IW-1:0]   index,
  output logic [NREQ-1:0] onehot
);
  logic [IW-1:0] cand;

  always_comb begin
    valid  = 1'b0;
    index  = '0;
    onehot = '0;
    cand   = '0;
    // ptr itself is visited last, so the previous owner has lowest priority
    for (int i = 1; i <= NREQ; i++) begin
      cand = IW'((32'(ptr) + i) % NREQ);
      if (!valid && req[cand]) begin
        valid        = 1'b1;
        index        = cand;
        onehot[cand] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/i2c_master_arbiter.sv
// Round-robin sharing of one I2C master engine between NREQ single-byte-write requesters,
// with per-transaction timeout supervision and status returned to the owner only.
module i2c_master_arbiter import i2c_arb_pkg::*; #(
  parameter int NREQ           = 4,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int TW             = $clog2(TIMEOUT_CYCLES+1)
) (
  input logic                  clk,
  input logic                  rst,
  i2c_master_arbiter_if.master bus
);
  localparam int IW = $clog2(NREQ);

  arb_state_e      state;
  logic [IW-1:0]   ptr, idx;
  logic [TW-1:0]   timer;
  logic [NREQ-1:0] grant_q, done_q, nack_q, timeout_q;
  logic            m_start_q;
  logic [I2C_ADDR_W-1:0] m_addr_q;
  logic [I2C_DATA_W-1:0] m_data_q;

  logic [NREQ-1:0][I2C_ADDR_W-1:0] addr_arr;
  logic [NREQ-1:0][I2C_DATA_W-1:0] data_arr;

  logic            pick_vld;
  logic [IW-1:0]   pick_idx;
  logic [NREQ-1:0] pick_oh;

  assign addr_arr = bus.req_addr;
  assign data_arr = bus.req_data;

  i2c_rr_picker #(.NREQ(NREQ), .IW(IW)) u_pick (
    .req    (bus.req),
    .ptr    (ptr),
    .valid  (pick_vld),
    .index  (pick_idx),
    .onehot (pick_oh)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= IW'(NREQ-1);
      idx       <= '0;
      timer     <= '0;
      grant_q   <= '0;
      done_q    <= '0;
      nack_q    <= '0;
      timeout_q <= '0;
      m_start_q <= 1'b0;
      m_addr_q  <= '0;
      m_data_q  <= '0;
    end else begin
      done_q    <= '0;
      nack_q    <= '0;
      timeout_q <= '0;
      m_start_q <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_vld && !bus.m_busy) begin
            idx       <= pick_idx;
            grant_q   <= pick_oh;
            m_addr_q  <= addr_arr[pick_idx];
            m_data_q  <= data_arr[pick_idx];
            m_start_q <= 1'b1;
            state     <= LAUNCH;
          end
        end
        LAUNCH: begin
          timer <= '0;
          state <= WAIT;
        end
        WAIT: begin
          // a completion arriving on the expiry cycle is reported as a real completion
          if (bus.m_done) begin
            done_q <= grant_q;
            nack_q <= bus.m_ack ? '0 : grant_q;
            state  <= RESP;
          end else if (timer == TW'(TIMEOUT_CYCLES-1)) begin
            done_q    <= grant_q;
            nack_q    <= grant_q;
            timeout_q <= grant_q;
            state     <= RESP;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        RESP: begin
          grant_q <= '0;
          ptr     <= idx;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.grant   = grant_q;
  assign bus.done    = done_q;
  assign bus.nack    = nack_q;
  assign bus.timeout = timeout_q;
  assign bus.m_start = m_start_q;
  assign bus.m_addr  = m_addr_q;
  assign bus.m_data  = m_data_q;
endmodule

// File: tb/tb_i2c_master_arbiter.sv
// Directed scenarios plus randomized traffic against a transaction-timeline model of the arbiter.
module tb_i2c_master_arbiter;
  localparam int NREQ = 4;
  localparam int TC   = 16;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0, failures = 0, cyc = 0;
  bit   chk_en = 1'b0;

  always #5 clk = ~clk;

  i2c_master_arbiter_if #(.NREQ(NREQ)) bus ();

  i2c_master_arbiter #(.NREQ(NREQ), .TIMEOUT_CYCLES(TC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // model: owner index, launch cycle, completion cycle (-1 = pending)
  int owner = -1, ptr = NREQ-1, st = 0, fin = -1;
  bit s_nack, s_to;
  logic [NREQ-1:0] e_grant = '0, e_done = '0, e_nack = '0, e_to = '0;
  logic            e_start = 1'b0;
  logic [6:0]      e_addr = '0;
  logic [7:0]      e_data = '0;

  logic              c_rst, c_busy, c_done, c_ack;
  logic [NREQ-1:0]   c_req;
  logic [7*NREQ-1:0] c_addr;
  logic [8*NREQ-1:0] c_data;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", nm, cyc, act, exp);
    end
  endtask

  function automatic int pick(input logic [NREQ-1:0] r, input int p);
    for (int k = 1; k <= NREQ; k++)
      if (r[(p+k)%NREQ]) return (p+k)%NREQ;
    return -1;
  endfunction

  // Expected outputs for cycle cyc from the inputs held during cycle cyc-1.
  task automatic model_update();
    e_start = 1'b0;
    e_done  = '0;
    e_nack  = '0;
    e_to    = '0;
    if (c_rst) begin
      owner = -1; ptr = NREQ-1; fin = -1; e_addr = '0; e_data = '0;
    end else if (owner < 0) begin
      if (c_req != '0 && !c_busy) begin
        owner   = pick(c_req, ptr);
        st      = cyc;
        fin     = -1;
        e_addr  = c_addr[owner*7 +: 7];
        e_data  = c_data[owner*8 +: 8];
        e_start = 1'b1;
      end
    end else if (fin < 0) begin
      if (cyc-1-st >= 1 && c_done) begin
        fin = cyc; s_nack = !c_ack; s_to = 1'b0;
      end else if (cyc-1-st == TC) begin
        fin = cyc; s_nack = 1'b1; s_to = 1'b1;
      end
    end else if (cyc-1 == fin) begin
      ptr = owner; owner = -1;
    end
    e_grant = '0;
    if (owner >= 0) e_grant[owner] = 1'b1;
    if (owner >= 0 && fin == cyc) begin
      e_done = e_grant;
      e_nack = s_nack ? e_grant : '0;
      e_to   = s_to ? e_grant : '0;
    end
  endtask

  task automatic step();
    c_rst = rst; c_req = bus.req; c_addr = bus.req_addr; c_data = bus.req_data;
    c_busy = bus.m_busy; c_done = bus.m_done; c_ack = bus.m_ack;
    @(posedge clk);
    #1;
    cyc++;
    model_update();
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("grant",   32'(bus.grant),   32'(e_grant));
      check("done",    32'(bus.done),    32'(e_done));
      check("nack",    32'(bus.nack),    32'(e_nack));
      check("timeout", 32'(bus.timeout), 32'(e_to));
      check("m_start", 32'(bus.m_start), 32'(e_start));
      check("m_addr",  32'(bus.m_addr),  32'(e_addr));
      check("m_data",  32'(bus.m_data),  32'(e_data));
    end
  end

  task automatic do_reset();
    rst = 1'b1; bus.req = '0; bus.m_busy = 1'b0; bus.m_done = 1'b0; bus.m_ack = 1'b0;
    step(); step();
    rst = 1'b0;
  endtask

  task automatic run_done(input int d, input bit ack);
    bus.m_done = 1'b0;
    repeat (d) step();
    bus.m_done = 1'b1; bus.m_ack = ack;
    step();
    bus.m_done = 1'b0;
  endtask

  task automatic wait_start(input int budget);
    int n = 0;
    while (bus.m_start !== 1'b1 && n < budget) begin step(); n++; end
    check("m_start_seen", 32'(bus.m_start), 32'd1);
  endtask

  initial begin
    logic [3:0] order [5];
    int n;
    int md_at;
    order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    rst = 1'b1;
    bus.req = '0; bus.req_addr = '0; bus.req_data = '0;
    bus.m_busy = 1'b0; bus.m_done = 1'b0; bus.m_ack = 1'b0;
    step();
    chk_en = 1'b1;

    // single write, ack after ten cycles
    do_reset();
    bus.req_addr[6:0] = 7'h42; bus.req_data[7:0] = 8'hA5; bus.req = 4'b0001;
    step();
    check("t1_grant", 32'(bus.grant), 32'h1);
    check("t1_start", 32'(bus.m_start), 32'h1);
    check("t1_addr",  32'(bus.m_addr), 32'h42);
    check("t1_data",  32'(bus.m_data), 32'hA5);
    run_done(10, 1'b1);
    check("t1_done", 32'(bus.done), 32'h1);
    check("t1_nack", 32'(bus.nack), 32'h0);
    bus.req = '0; step(); step();

    // all requesting: rotation 0,1,2,3,0
    do_reset();
    bus.req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_start(20);
      check("t2_grant", 32'(bus.grant), 32'(order[k]));
      run_done(5, 1'b1);
      check("t2_done", 32'(bus.done), 32'(order[k]));
    end
    bus.req = '0; step(); step();

    // busy engine holds off the launch
    do_reset();
    bus.m_busy = 1'b1; bus.req = 4'b0010;
    repeat (20) begin
      step();
      check("t3_busy_start", 32'(bus.m_start), 32'h0);
      check("t3_busy_grant", 32'(bus.grant), 32'h0);
    end
    bus.m_busy = 1'b0;
    step();
    check("t3_grant", 32'(bus.grant), 32'h2);
    run_done(3, 1'b1);
    bus.req = '0; step(); step();

    // timeout: done exactly TC+1 cycles after m_start
    do_reset();
    bus.req = 4'b0100;
    wait_start(5);
    n = 0;
    while (bus.done == '0 && n < 40) begin step(); n++; end
    check("t4_latency", 32'(n), 32'd17);
    check("t4_done",    32'(bus.done), 32'h4);
    check("t4_nack",    32'(bus.nack), 32'h4);
    check("t4_timeout", 32'(bus.timeout), 32'h4);
    bus.req = '0; step();
    check("t4_idle_grant", 32'(bus.grant), 32'h0);
    step();

    // m_done with nack on the expiry cycle wins over the timeout
    bus.req = 4'b1000;
    wait_start(5);
    run_done(16, 1'b0);
    check("t5_done",    32'(bus.done), 32'h8);
    check("t5_nack",    32'(bus.nack), 32'h8);
    check("t5_timeout", 32'(bus.timeout), 32'h0);
    bus.req = '0; step(); step();

    // reset during WAIT
    do_reset();
    bus.req = 4'b0100;
    wait_start(5);
    step(); step(); step();
    rst = 1'b1;
    step();
    check("t6_grant_rst", 32'(bus.grant), 32'h0);
    check("t6_done_rst",  32'(bus.done), 32'h0);
    rst = 1'b0; bus.req = 4'b1001;
    step();
    check("t6_grant", 32'(bus.grant), 32'h1);
    run_done(2, 1'b1);
    bus.req = '0; step(); step();

    // randomized traffic with a loosely modelled engine
    md_at = -1;
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 3) == 0) bus.req = NREQ'($urandom);
      if ($urandom_range(0, 7) == 0) begin
        bus.req_addr = (7*NREQ)'({$urandom, $urandom});
        bus.req_data = (8*NREQ)'({$urandom, $urandom});
      end
      bus.m_busy = ($urandom_range(0, 9) < 3);
      bus.m_done = (cyc == md_at) || ($urandom_range(0, 49) == 0);
      bus.m_ack  = ($urandom_range(0, 3) != 0);
      step();
      if (bus.m_start === 1'b1) md_at = cyc + int'($urandom_range(0, 17));
    end
    rst = 1'b0; bus.req = '0; bus.m_done = 1'b0;
    repeat (25) step();
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
